task_dispatcher: RTL and testbench
==================================

# task_dispatcher

MCU-side command source for the FPGA task blocks. It watches the 8-bit ready/priority advertisements the task blocks publish for one node, selects the highest-priority ready task, and drives the 16-bit operation word into that node's task blocks. Host-requested control operations (ready, suspend, wait, kill, set priority, set execution hits, kill overall) are carried on the same op bus and take precedence over automatic execution. One instance exists per node.

## Interface
Parameters:
- NUM_TASKS, 4: number of advertisement slots (1..8)
- HOLD_CYCLES, 4: cycles an op word is held on the bus (>=1)
- GAP_CYCLES, 2: cycles of 16'h0000 after each op word (>=1)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- adv  in  8*NUM_TASKS  slot i = adv[8i+7:8i]; [7:4] priority, [3:0] task id; 8'h00 = not ready
- exec_en  in  1  enables automatic Execute issue
- cmd_valid  in  1  host op request
- cmd_ready  out  1  high in IDLE; request accepted when cmd_valid && cmd_ready
- cmd_task  in  4  target task id
- cmd_op  in  4  opcode (0001 ready, 0010 suspend, 0011 wait, 0100 kill, 0101 priority, 0110 exe hit, 0111 execute, 1100 kill overall)
- cmd_arg  in  4  argument nibble
- op_word  out  16  {4'b0000, task, op, arg}; 16'h0000 = no operation
- busy  out  1  high in any state other than IDLE
- issue_pulse  out  1  one-cycle pulse on the first cycle an op word is driven
- issued_task  out  4  task id of the most recent issued op
- exec_count  out  16  count of automatic Execute ops issued

## Operation
- States: IDLE, HOLD, GAP.
- IDLE: cmd_ready=1, op_word=0. Priority of decisions in one cycle:
  1. cmd_valid=1: latch {cmd_task, cmd_op, cmd_arg}; go to HOLD.
  2. Else exec_en=1 and any slot nonzero: latch {winner id, 4'b0111, 4'b0000}; exec_count += 1 (wraps 16'hFFFF -> 0); go to HOLD.
  3. Else stay in IDLE.
- Winner: largest adv[7:4] among nonzero slots; ties go to lowest slot index. A slot with priority 0 and nonzero id is ready and eligible.
- HOLD: op_word = latched word for HOLD_CYCLES cycles, then GAP.
- GAP: op_word = 16'h0000 for GAP_CYCLES cycles, then IDLE. The zero gap guarantees that back-to-back identical ops appear as a bus change to the task blocks.
- Opcodes are passed through unchecked. An opcode outside the listed set is still driven for the full HOLD/GAP sequence.
- issued_task updates on entry to HOLD and holds its value otherwise.
- adv changes during HOLD or GAP are ignored. Selection uses only adv as sampled in the IDLE decision cycle.

## Timing
- Reset (async assert): state=IDLE, op_word=0, cmd_ready=1, busy=0, issue_pulse=0, issued_task=0, exec_count=0, internal counters=0. All outputs are registered.
- Decision at IDLE edge t: op_word valid and issue_pulse=1 in cycle t+1. op_word stays valid through cycle t+HOLD_CYCLES, is 0 for the next GAP_CYCLES cycles, and IDLE is re-entered at cycle t+HOLD_CYCLES+GAP_CYCLES+1.
- Issue period is HOLD_CYCLES+GAP_CYCLES+1 cycles. Defaults give 7.
- busy is high from t+1 through the last GAP cycle. cmd_ready = !busy.
- Reset asserted mid-HOLD: op_word drops to 0 immediately. The aborted op is not retried.
- cmd_valid asserted while busy: ignored. The host holds the request until cmd_ready.

## Test plan
- Reset, then adv={8'h00,8'h00,8'h53,8'h23}, exec_en=1 -> op_word=16'h0370 for 4 cycles, 16'h0000 for 2 cycles, issued_task=3, exec_count=1.
- Tie: slot0=8'h72, slot2=8'h74 -> task 2 chosen (op_word=16'h0270). Then slot2=8'h74 alone ready -> task 4 chosen (16'h0470).
- cmd_valid with task=3, op=1100, arg=0 in the same cycle as ready adv, exec_en=1 -> op_word=16'h03C0, exec_count unchanged.
- Two consecutive cmds task=3, op=0101, arg=9 -> 16'h0359, then 2 zero cycles, then 16'h0359 again. Second cmd_ready rises 7 cycles after the first accept.
- exec_count preset path: run 65536 auto issues (or force 16'hFFFF) -> next issue wraps exec_count to 0.
- RST_N low during the 2nd HOLD cycle -> op_word=0, busy=0 asynchronously. After release, the next IDLE decision issues normally.

Source files
------------

// File: rtl/task_dispatcher.sv
// Per-node op-bus source: picks the highest-priority ready task or a host command
// and drives the op word for a fixed hold window followed by a zero gap.
module task_dispatcher #(
  parameter int unsigned NUM_TASKS   = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [8*NUM_TASKS-1:0] adv,
  input  logic                   exec_en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_task,
  input  logic [3:0]             cmd_op,
  input  logic [3:0]             cmd_arg,
  output logic [15:0]            op_word,
  output logic                   busy,
  output logic                   issue_pulse,
  output logic [3:0]             issued_task,
  output logic [15:0]            exec_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHold = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  localparam logic [3:0] OpExecute = 4'b0111;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     op_word_q, op_word_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            issue_q, issue_d;
  logic [3:0]      issued_task_q, issued_task_d;
  logic [15:0]     exec_count_q;
  logic            exec_inc;

  logic       win_found;
  logic [3:0] win_prio;
  logic [3:0] win_id;

  // Strictly-greater compare keeps the lowest slot index on priority ties.
  always_comb begin
    win_found = 1'b0;
    win_prio  = 4'h0;
    win_id    = 4'h0;
    for (int i = 0; i < int'(NUM_TASKS); i++) begin
      if (adv[8*i +: 8] != 8'h00 && (!win_found || adv[8*i+4 +: 4] > win_prio)) begin
        win_found = 1'b1;
        win_prio  = adv[8*i+4 +: 4];
        win_id    = adv[8*i +: 4];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_word_d     = op_word_q;
    busy_d        = busy_q;
    ready_d       = ready_q;
    issue_d       = 1'b0;
    issued_task_d = issued_task_q;
    exec_inc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_word_d     = {4'h0, cmd_task, cmd_op, cmd_arg};
          issued_task_d = cmd_task;
          state_d       = StHold;
          cnt_d         = '0;
          busy_d        = 1'b1;
          ready_d       = 1'b0;
          issue_d       = 1'b1;
        end else if (exec_en && win_found) begin
          op_word_d     = {4'h0, win_id, OpExecute, 4'h0};
          issued_task_d = win_id;
          state_d       = StHold;
          cnt_d         = '0;
          busy_d        = 1'b1;
          ready_d       = 1'b0;
          issue_d       = 1'b1;
          exec_inc      = 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d   = StGap;
          cnt_d     = '0;
          op_word_d = 16'h0000;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        op_word_d = 16'h0000;
        busy_d    = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      op_word_q     <= 16'h0000;
      busy_q        <= 1'b0;
      ready_q       <= 1'b1;
      issue_q       <= 1'b0;
      issued_task_q <= 4'h0;
      exec_count_q  <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_word_q     <= op_word_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      issue_q       <= issue_d;
      issued_task_q <= issued_task_d;
      // Wraps naturally from 16'hFFFF to 0.
      if (exec_inc) exec_count_q <= exec_count_q + 16'd1;
    end
  end

  assign op_word     = op_word_q;
  assign busy        = busy_q;
  assign cmd_ready   = ready_q;
  assign issue_pulse = issue_q;
  assign issued_task = issued_task_q;
  assign exec_count  = exec_count_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: a vector table of single issues plus
// hand-written sequences for idle, back-to-back, counter wrap and mid-hold reset.
module tb_task_dispatcher;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] adv = '0;
  logic        exec_en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_task = '0;
  logic [3:0]  cmd_op = '0;
  logic [3:0]  cmd_arg = '0;
  logic [15:0] op_word;
  logic        busy;
  logic        issue_pulse;
  logic [3:0]  issued_task;
  logic [15:0] exec_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt = '0;

  task_dispatcher #(
    .NUM_TASKS  (4),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .adv        (adv),
    .exec_en    (exec_en),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_task   (cmd_task),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .op_word    (op_word),
    .busy       (busy),
    .issue_pulse(issue_pulse),
    .issued_task(issued_task),
    .exec_count (exec_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] adv;
    logic        exec_en;
    logic        cmd_valid;
    logic [3:0]  tid;
    logic [3:0]  op;
    logic [3:0]  arg;
    logic [15:0] exp_word;
    logic        auto_inc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_idle", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] w;
    w = v.exp_word;
    wait_idle();
    adv       = v.adv;
    exec_en   = v.exec_en;
    cmd_valid = v.cmd_valid;
    cmd_task  = v.tid;
    cmd_op    = v.op;
    cmd_arg   = v.arg;
    tick();
    if (v.auto_inc) exp_cnt = exp_cnt + 16'd1;
    chk("first_word", {16'd0, op_word}, {16'd0, w});
    chk("issue_pulse", {31'd0, issue_pulse}, 32'd1);
    chk("busy_issue", {31'd0, busy}, 32'd1);
    chk("ready_issue", {31'd0, cmd_ready}, 32'd0);
    chk("issued_task", {28'd0, issued_task}, {28'd0, w[11:8]});
    chk("exec_count", {16'd0, exec_count}, {16'd0, exp_cnt});
    cmd_valid = 1'b0;
    exec_en   = 1'b0;
    // Selection must not follow adv after the decision cycle.
    adv       = 32'hFF00_0000;
    for (int k = 1; k < HOLD; k++) begin
      tick();
      chk("hold_word", {16'd0, op_word}, {16'd0, w});
      chk("hold_pulse", {31'd0, issue_pulse}, 32'd0);
    end
    for (int k = 0; k < GAP; k++) begin
      tick();
      chk("gap_word", {16'd0, op_word}, 32'd0);
      chk("gap_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_task", {28'd0, issued_task}, {28'd0, w[11:8]});
    adv = '0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_5323, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0370, 1'b1};
    vecs[1] = '{32'h0074_0072, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0270, 1'b1};
    vecs[2] = '{32'h0074_0000, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0470, 1'b1};
    vecs[3] = '{32'h0000_5323, 1'b1, 1'b1, 4'h3, 4'hC, 4'h0, 16'h03C0, 1'b0};
    vecs[4] = '{32'h0000_0500, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0570, 1'b1};
    vecs[5] = '{32'h1000_0500, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0070, 1'b1};
    vecs[6] = '{32'h0000_0000, 1'b0, 1'b1, 4'hA, 4'hF, 4'h5, 16'h0AF5, 1'b0};
    vecs[7] = '{32'hF1E2_D3C4, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0170, 1'b1};

    #12;
    chk("rst_word", {16'd0, op_word}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulse", {31'd0, issue_pulse}, 32'd0);
    chk("rst_task", {28'd0, issued_task}, 32'd0);
    chk("rst_count", {16'd0, exec_count}, 32'd0);
    RST_N = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // No issue without exec_en, and none with exec_en but nothing ready.
    adv = 32'h0000_0042;
    exec_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_en_busy", {31'd0, busy}, 32'd0);
      chk("no_en_word", {16'd0, op_word}, 32'd0);
    end
    adv = '0;
    exec_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_ready_busy", {31'd0, busy}, 32'd0);
    end
    exec_en = 1'b0;
    chk("no_issue_count", {16'd0, exec_count}, {16'd0, exp_cnt});

    // Host keeps a command asserted across two issues.
    begin
      int n;
      wait_idle();
      cmd_valid = 1'b1;
      cmd_task  = 4'h3;
      cmd_op    = 4'h5;
      cmd_arg   = 4'h9;
      tick();
      chk("b2b_first", {16'd0, op_word}, 32'h0359);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
        tick();
        n++;
        if (n < HOLD) chk("b2b_hold", {16'd0, op_word}, 32'h0359);
        else if (n < HOLD + GAP) chk("b2b_gap", {16'd0, op_word}, 32'd0);
      end
      chk("b2b_ready_delay", n, HOLD + GAP);
      tick();
      chk("b2b_second", {16'd0, op_word}, 32'h0359);
      chk("b2b_pulse", {31'd0, issue_pulse}, 32'd1);
      cmd_valid = 1'b0;
      wait_idle();
    end

    // Counter wrap: preset to FFFF, next auto issue must give 0.
    force dut.exec_count_q = 16'hFFFF;
    tick();
    release dut.exec_count_q;
    tick();
    exp_cnt = 16'hFFFF;
    chk("preset_count", {16'd0, exec_count}, 32'h0000FFFF);
    run_vec('{32'h0000_0091, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0170, 1'b1});
    chk("wrap_count", {16'd0, exec_count}, 32'd0);

    // Reset in the second HOLD cycle.
    wait_idle();
    adv = 32'h0000_0091;
    exec_en = 1'b1;
    tick();
    exec_en = 1'b0;
    tick();
    chk("pre_rst_word", {16'd0, op_word}, 32'h0170);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_word", {16'd0, op_word}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_count", {16'd0, exec_count}, 32'd0);
    exp_cnt = 16'h0000;
    @(posedge CLK);
    #2 RST_N = 1'b1;
    tick();
    chk("post_rst_idle", {16'd0, op_word}, 32'd0);
    run_vec('{32'h0000_0091, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0170, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
